sad_accumulator: RTL and testbench
==================================

Name: sad_accumulator

Overview:
- Downstream consumer of the absolute subtraction stage; accumulates a stream of unsigned |A-B| values into a sum of absolute differences (SAD) per block of BLOCK_LEN samples.
- Input side: valid/ready handshake. Output side: registered sum and sample count under a valid/ready handshake.
- Supports early block termination (flush) for partial blocks.

Parameters:
DATA_W, 4, width of incoming |A-B| value (unsigned, range 0..15)
BLOCK_LEN, 4, samples per block; must be >= 2
SUM_W, 6, accumulator/result width; must satisfy SUM_W >= DATA_W + clog2(BLOCK_LEN), so overflow is impossible
CNT_W, 3, count width; must satisfy CNT_W >= clog2(BLOCK_LEN+1)

Ports:
i_sad_accumulator_clk  input  1  clock, rising edge
i_sad_accumulator_rst  input  1  reset, asynchronous, active-high
i_sad_accumulator_valid  input  1  input value valid
i_sad_accumulator_value  input  DATA_W  unsigned |A-B| value
o_sad_accumulator_ready  output  1  block accepts input this cycle
i_sad_accumulator_flush  input  1  end current block early (synchronous)
o_sad_accumulator_sum_valid  output  1  result valid
i_sad_accumulator_sum_ready  input  1  downstream accepts result
o_sad_accumulator_sum  output  SUM_W  block SAD, zero-extended sum
o_sad_accumulator_count  output  CNT_W  samples contained in the result

Behaviour:
- Reset: state=ACCUM, acc=0, cnt=0, ready=1, sum_valid=0, sum=0, count=0. Reset takes effect immediately regardless of clock, including mid-block and during HOLD; the partial block is discarded.
- States: ACCUM and HOLD.
- ACCUM:
  - ready=1. A sample is accepted on a rising edge when valid && ready.
  - On accept: acc <= acc + value (zero-extended to SUM_W); cnt <= cnt + 1.
  - Valid low: acc and cnt hold. Gaps are allowed with no timeout.
- Block end, evaluated at the edge:
  - Condition: (accept && cnt == BLOCK_LEN-1), or (flush && (cnt != 0 || accept)).
  - On block end: sum <= acc + accepted value (or acc alone if nothing accepted); count <= cnt + accept.
  - Also: sum_valid <= 1, acc <= 0, cnt <= 0, state <= HOLD.
  - Latency: sum_valid rises one cycle after the edge that accepts the last sample, and the sum includes that sample.
- Flush rules:
  - A sample accepted in the flush cycle is included in the result.
  - Flush with cnt==0 and no accept is ignored: no output, state unchanged.
  - Flush in HOLD is ignored.
- HOLD:
  - ready=0; input valid is ignored and not accepted.
  - sum, count and sum_valid hold stable until sum_ready is sampled high.
  - On edge with sum_ready=1: sum_valid <= 0, state <= ACCUM; sum and count keep their last values.
  - One-cycle input bubble per block is accepted by design.
- Arithmetic: unsigned only. The parameter constraints exclude overflow; no saturation logic.
- The value input is not checked beyond its width; any 0..2^DATA_W-1 is legal.
- ready is a registered-state decode (ready = state==ACCUM), with no combinational path from sum_ready.

Test Plan:
- Basic block, BLOCK_LEN=4, sum_ready=1: values 2,2,2,5 on consecutive cycles -> sum_valid high one cycle after 4th accept; sum=11, count=4; ready low exactly one cycle, then next block accepted.
- Max values: four samples of 15 -> sum=60, count=4, no overflow. Next block of 0,0,0,1 -> sum=1, confirming acc cleared.
- Backpressure: complete a block (3,3,3,3) with sum_ready=0 for 3 cycles while valid=1 and value=7 -> sum=12 stable, ready=0, the 7s are not accepted. Raise sum_ready -> sum_valid drops next edge; next block starts from acc=0.
- Flush: accept 8,5, then pulse flush with valid=0 -> sum=13, count=2. Then flush concurrent with accepted 4 after one sample 6 -> sum=10, count=2. Flush at cnt=0 with valid=0 -> no sum_valid.
- Gapped input: 1, idle 2 cycles, 2, idle, 3, 4 -> sum=10, count=4 only after 4th accept.
- Reset mid-operation: accept 9,9, assert rst asynchronously between edges -> sum_valid=0, ready=1, sum=0 immediately. After release, 1,1,1,1 -> sum=4 with no residue. Reset during HOLD clears sum_valid immediately.

Source files
------------

// File: rtl/sad_accumulator.sv
// Accumulates a stream of unsigned |A-B| samples into a per-block SAD.
// Results are held under a valid/ready handshake; flush closes a partial block.
module sad_accumulator #(
    parameter int DATA_W    = 4,
    parameter int BLOCK_LEN = 4,
    parameter int SUM_W     = 6,
    parameter int CNT_W     = 3
) (
    input  logic              i_sad_accumulator_clk,
    input  logic              i_sad_accumulator_rst,
    input  logic              i_sad_accumulator_valid,
    input  logic [DATA_W-1:0] i_sad_accumulator_value,
    output logic              o_sad_accumulator_ready,
    input  logic              i_sad_accumulator_flush,
    output logic              o_sad_accumulator_sum_valid,
    input  logic              i_sad_accumulator_sum_ready,
    output logic [SUM_W-1:0]  o_sad_accumulator_sum,
    output logic [CNT_W-1:0]  o_sad_accumulator_count
);

    generate
        if (BLOCK_LEN < 2) begin : g_bad_len
            $error("BLOCK_LEN must be >= 2");
        end
        if (SUM_W < DATA_W + $clog2(BLOCK_LEN)) begin : g_bad_sum
            $error("SUM_W too narrow for a full block");
        end
        if (CNT_W < $clog2(BLOCK_LEN + 1)) begin : g_bad_cnt
            $error("CNT_W too narrow for BLOCK_LEN");
        end
    endgenerate

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    state_t           state_q;
    logic [SUM_W-1:0] acc_q, sum_q;
    logic [CNT_W-1:0] cnt_q, count_q;
    logic             sum_valid_q;

    logic             accept;
    logic             block_end;
    logic [SUM_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;

    assign accept = i_sad_accumulator_valid && (state_q == ACCUM);
    assign acc_d  = acc_q + (accept ? SUM_W'(i_sad_accumulator_value) : '0);
    assign cnt_d  = cnt_q + CNT_W'(accept);

    // A flush with nothing pending and nothing arriving has no block to close.
    assign block_end = (state_q == ACCUM) &&
                       ((accept && (cnt_q == LAST)) ||
                        (i_sad_accumulator_flush && ((cnt_q != '0) || accept)));

    always_ff @(posedge i_sad_accumulator_clk or posedge i_sad_accumulator_rst) begin
        if (i_sad_accumulator_rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (block_end) begin
                        sum_q       <= acc_d;
                        count_q     <= cnt_d;
                        sum_valid_q <= 1'b1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= HOLD;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (i_sad_accumulator_sum_ready) begin
                        sum_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign o_sad_accumulator_ready     = (state_q == ACCUM);
    assign o_sad_accumulator_sum_valid = sum_valid_q;
    assign o_sad_accumulator_sum       = sum_q;
    assign o_sad_accumulator_count     = count_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// Scoreboard bench for sad_accumulator: expected results are queued as
// stimulus is driven and popped when a result handshake completes.
module tb_sad_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] value = '0;
    logic       flush = 1'b0;
    logic       sum_ready = 1'b1;
    logic       ready, sum_valid;
    logic [5:0] sum;
    logic [2:0] count;

    typedef struct packed {
        logic [5:0] sum;
        logic [2:0] cnt;
    } res_t;

    res_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    sad_accumulator #(.DATA_W(4), .BLOCK_LEN(4), .SUM_W(6), .CNT_W(3)) dut (
        .i_sad_accumulator_clk      (clk),
        .i_sad_accumulator_rst      (rst),
        .i_sad_accumulator_valid    (valid),
        .i_sad_accumulator_value    (value),
        .o_sad_accumulator_ready    (ready),
        .i_sad_accumulator_flush    (flush),
        .o_sad_accumulator_sum_valid(sum_valid),
        .i_sad_accumulator_sum_ready(sum_ready),
        .o_sad_accumulator_sum      (sum),
        .o_sad_accumulator_count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // A result handshake completes on the posedge following a negedge with both high.
    always @(negedge clk) begin
        if (!rst && sum_valid && sum_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("count", 32'(count), 32'(e.cnt));
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] val, input logic fl);
        valid = v;
        value = val;
        flush = fl;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic push(input int s, input int c);
        res_t r;
        r.sum = 6'(s);
        r.cnt = 3'(c);
        q.push_back(r);
    endtask

    task automatic send_block(input int a, input int b, input int c, input int d);
        push(a + b + c + d, 4);
        cyc(1'b1, 4'(a), 1'b0);
        cyc(1'b1, 4'(b), 1'b0);
        cyc(1'b1, 4'(c), 1'b0);
        cyc(1'b1, 4'(d), 1'b0);
        chk("blk_valid", 32'(sum_valid), 1);
        cyc(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_valid", 32'(sum_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_count", 32'(count), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic block with latency and one-cycle bubble
        push(11, 4);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        chk("basic_early", 32'(sum_valid), 0);
        cyc(1'b1, 4'd5, 1'b0);
        chk("basic_valid", 32'(sum_valid), 1);
        chk("basic_ready_low", 32'(ready), 0);
        cyc(1'b0, 4'd0, 1'b0);
        chk("basic_ready_back", 32'(ready), 1);
        chk("basic_valid_drop", 32'(sum_valid), 0);

        send_block(15, 15, 15, 15);
        send_block(0, 0, 0, 1);

        // Backpressure: held result, stalled input must not be accepted
        sum_ready = 1'b0;
        push(12, 4);
        repeat (4) cyc(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'd7, 1'b0);
            chk("bp_valid", 32'(sum_valid), 1);
            chk("bp_ready", 32'(ready), 0);
            chk("bp_sum", 32'(sum), 12);
        end
        sum_ready = 1'b1;
        cyc(1'b0, 4'd0, 1'b0);
        chk("bp_drop", 32'(sum_valid), 0);
        send_block(1, 2, 3, 4);

        // Flush with idle input
        push(13, 2);
        cyc(1'b1, 4'd8, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b0, 4'd0, 1'b1);
        chk("flush_valid", 32'(sum_valid), 1);
        cyc(1'b0, 4'd0, 1'b0);
        // Flush concurrent with an accepted sample
        push(10, 2);
        cyc(1'b1, 4'd6, 1'b0);
        cyc(1'b1, 4'd4, 1'b1);
        chk("flush_acc_valid", 32'(sum_valid), 1);
        cyc(1'b0, 4'd0, 1'b0);
        // Flush with nothing pending
        cyc(1'b0, 4'd0, 1'b1);
        chk("flush_empty", 32'(sum_valid), 0);
        chk("flush_empty_rdy", 32'(ready), 1);

        // Gapped input
        push(10, 4);
        cyc(1'b1, 4'd1, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd3, 1'b0);
        chk("gap_early", 32'(sum_valid), 0);
        cyc(1'b1, 4'd4, 1'b0);
        chk("gap_valid", 32'(sum_valid), 1);
        cyc(1'b0, 4'd0, 1'b0);

        // Asynchronous reset mid-block
        cyc(1'b1, 4'd9, 1'b0);
        cyc(1'b1, 4'd9, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(sum_valid), 0);
        chk("mid_rst_ready", 32'(ready), 1);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_count", 32'(count), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_block(1, 1, 1, 1);

        // Asynchronous reset while holding a result
        sum_ready = 1'b0;
        repeat (4) cyc(1'b1, 4'd2, 1'b0);
        chk("hold_valid", 32'(sum_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("hold_rst_valid", 32'(sum_valid), 0);
        chk("hold_rst_ready", 32'(ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        sum_ready = 1'b1;
        cyc(1'b0, 4'd0, 1'b0);
        chk("hold_rst_quiet", 32'(sum_valid), 0);

        chk("queue_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
